// File: rtl/leaf_pkg.sv
// Shared constants, arbiter state type and packet field helpers for the leaf page arbiter.
package leaf_pkg;

    localparam int unsigned PKT_W_DEF = 49;
    localparam int unsigned SEL_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } arb_state_t;

    // Valid flag sits in the MSB of every packet.
    function automatic int unsigned valid_idx(input int unsigned pkt_w);
        return pkt_w - 1;
    endfunction

    // Extract pkt[sel_msb -: sel_w]; packets are zero-extended to 128 bits by the caller.
    function automatic int unsigned page_sel(input logic [127:0] pkt,
                                             input int unsigned  sel_msb,
                                             input int unsigned  sel_w);
        return 32'(pkt >> (sel_msb + 1 - sel_w)) & ((32'd1 << sel_w) - 32'd1);
    endfunction

endpackage

// File: rtl/leaf_if.sv
// Bundle of leaf-side and page-side packet signals shared by the arbiter and its environment.
interface leaf_if
    import leaf_pkg::*;
#(
    parameter int unsigned NUM_PAGES = 2,
    parameter int unsigned PKT_W     = PKT_W_DEF
);

    logic                         ap_start;
    logic [PKT_W-1:0]             din_leaf_bft2interface;
    logic [PKT_W-1:0]             dout_leaf_interface2bft;
    logic                         resend;
    logic [NUM_PAGES*PKT_W-1:0]   din_page;
    logic [NUM_PAGES*PKT_W-1:0]   dout_page;
    logic [NUM_PAGES-1:0]         resend_page;
    logic [NUM_PAGES-1:0]         ap_start_page;

    modport slave (
        input  ap_start, din_leaf_bft2interface, resend, dout_page,
        output dout_leaf_interface2bft, din_page, resend_page, ap_start_page
    );

    modport master (
        output ap_start, din_leaf_bft2interface, resend, dout_page,
        input  dout_leaf_interface2bft, din_page, resend_page, ap_start_page
    );

endinterface

// File: rtl/leaf_sync_fifo.sv
// Show-ahead synchronous FIFO; a push on a full FIFO is accepted only when a pop frees a slot.
module leaf_sync_fifo
    import leaf_pkg::*;
#(
    parameter int unsigned PKT_W      = PKT_W_DEF,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [PKT_W-1:0] din,
    output logic [PKT_W-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PKT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop && !empty_c;
    assign do_push   = push && (!full_c || do_pop);
    assign rd_data_c = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/leaf_page_arbiter.sv
// Shares one BFT leaf port among NUM_PAGES pages: steers downstream packets by page-select
// and merges per-page upstream FIFOs round-robin with resend back-pressure.
module leaf_page_arbiter
    import leaf_pkg::*;
#(
    parameter int unsigned NUM_PAGES  = 2,
    parameter int unsigned PKT_W      = PKT_W_DEF,
    parameter int unsigned SEL_W      = SEL_W_DEF,
    parameter int unsigned SEL_MSB    = 47,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic  clk_400,
    input  logic  reset_400,
    leaf_if.slave bus
);

    localparam int unsigned VLD   = valid_idx(PKT_W);
    localparam int unsigned PTR_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    arb_state_t                 state;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PKT_W-1:0]           out_word;
    logic [NUM_PAGES*PKT_W-1:0] din_page_q;
    logic [NUM_PAGES-1:0]       resend_page_q;
    logic [NUM_PAGES-1:0]       ap_start_page_q;
    logic                       drop_sticky;

    logic [NUM_PAGES-1:0]       page_valid;
    logic [NUM_PAGES-1:0]       full_vec;
    logic [NUM_PAGES-1:0]       empty_vec;
    logic [NUM_PAGES-1:0]       pop_vec;
    logic [PKT_W-1:0]           fifo_data [NUM_PAGES];

    logic                       in_valid;
    int unsigned                sel_idx;
    logic                       gnt_valid;
    logic [PTR_W-1:0]           gnt_idx;
    logic [PTR_W-1:0]           rr_next_c;
    logic                       advance_c;
    int                         scan_idx;

    assign in_valid = bus.din_leaf_bft2interface[VLD];
    assign sel_idx  = page_sel(128'(bus.din_leaf_bft2interface), SEL_MSB, SEL_W);

    // Downstream steering, ap_start fan-out and the out-of-range drop flag.
    always_ff @(posedge clk_400) begin
        if (reset_400) begin
            din_page_q      <= '0;
            ap_start_page_q <= '0;
            drop_sticky     <= 1'b0;
        end else begin
            ap_start_page_q <= {NUM_PAGES{bus.ap_start}};
            for (int i = 0; i < int'(NUM_PAGES); i++) begin
                din_page_q[i*PKT_W +: PKT_W] <= (in_valid && sel_idx == i)
                                                ? bus.din_leaf_bft2interface : '0;
            end
            drop_sticky <= drop_sticky || (in_valid && sel_idx >= NUM_PAGES);
        end
    end

    for (genvar g = 0; g < int'(NUM_PAGES); g++) begin : g_page
        assign page_valid[g] = bus.dout_page[g*PKT_W + VLD];

        leaf_sync_fifo #(
            .PKT_W      (PKT_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_400),
            .rst       (reset_400),
            .push      (page_valid[g]),
            .pop       (pop_vec[g]),
            .din       (bus.dout_page[g*PKT_W +: PKT_W]),
            .rd_data_c (fifo_data[g]),
            .full_c    (full_vec[g]),
            .empty_c   (empty_vec[g])
        );
    end

    // First non-empty FIFO at or after rr_ptr; descending scan lets the nearest one win.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = int'(NUM_PAGES) - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % int'(NUM_PAGES);
            if (!empty_vec[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // The presented word is retired unless the leaf asks for it again.
    always_comb begin
        advance_c = (state == IDLE) || !bus.resend;
        rr_next_c = PTR_W'((int'(gnt_idx) + 1) % int'(NUM_PAGES));
        pop_vec   = '0;
        if (advance_c && gnt_valid) pop_vec[gnt_idx] = 1'b1;
    end

    // A full FIFO refusing a valid word asks the page to present it again.
    always_ff @(posedge clk_400) begin
        if (reset_400) resend_page_q <= '0;
        else           resend_page_q <= page_valid & full_vec & ~pop_vec;
    end

    always_ff @(posedge clk_400) begin
        if (reset_400) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            out_word <= '0;
        end else begin
            case (state)
                IDLE:       if (gnt_valid) state <= SEND;
                SEND, HOLD: begin
                    if (bus.resend)      state <= HOLD;
                    else if (gnt_valid)  state <= SEND;
                    else                 state <= IDLE;
                end
                default:    state <= IDLE;
            endcase
            if (advance_c) begin
                out_word <= gnt_valid ? fifo_data[gnt_idx] : '0;
                if (gnt_valid) rr_ptr <= rr_next_c;
            end
        end
    end

    assign bus.dout_leaf_interface2bft = out_word;
    assign bus.din_page                = din_page_q;
    assign bus.resend_page             = resend_page_q;
    assign bus.ap_start_page           = ap_start_page_q;

endmodule
